// File: rtl/mem_ctrl.sv
// Byte-serial RAM sequencer shared by instruction fetch and load/store.
// Splits word/half/byte accesses into byte transfers and assembles reads little-endian.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter bit MEM_PRIO   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [31:0]           if_data_o,
    output logic                  if_done_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_size_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    output logic [31:0]           mem_rdata_o,
    output logic                  mem_done_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_wr_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, TAIL = 2'd2, DONE = 2'd3} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  we_q, we_d;
    logic                  own_mem_q, own_mem_d;
    logic [1:0]            k_q, k_d;
    logic [1:0]            last_q, last_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           result_q, result_d;

    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_wr_q, ram_wr_d;
    logic [7:0]            ram_dout_q, ram_dout_d;
    logic                  if_done_q, if_done_d;
    logic                  mem_done_q, mem_done_d;
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;

    logic                  grant_any, grant_mem;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [31:0]           sel_wdata;
    logic [1:0]            sel_last;
    logic [1:0]            cap_idx;

    assign grant_any = if_req_i | mem_req_i;
    assign grant_mem = mem_req_i & (~if_req_i | MEM_PRIO);

    // last_q holds the index of the final byte (N-1), so fetches always use 3
    always_comb begin
        sel_addr  = if_addr_i;
        sel_we    = 1'b0;
        sel_wdata = 32'd0;
        sel_last  = 2'd3;
        if (grant_mem) begin
            sel_addr  = mem_addr_i;
            sel_we    = mem_we_i;
            sel_wdata = mem_wdata_i;
            case (mem_size_i)
                2'b00:   sel_last = 2'd0;
                2'b01:   sel_last = 2'd1;
                default: sel_last = 2'd3;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = XFER;
            XFER:    if (k_q == last_q) state_d = we_q ? DONE : TAIL;
            TAIL:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        base_d      = base_q;
        we_d        = we_q;
        own_mem_d   = own_mem_q;
        k_d         = k_q;
        last_d      = last_q;
        wdata_d     = wdata_q;
        result_d    = result_q;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = 32'd0;
        mem_rdata_d = 32'd0;
        cap_idx     = k_q - 2'd1;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    base_d     = sel_addr;
                    we_d       = sel_we;
                    own_mem_d  = grant_mem;
                    k_d        = 2'd0;
                    last_d     = sel_last;
                    wdata_d    = sel_wdata;
                    result_d   = 32'd0;
                    ram_addr_d = sel_addr;
                    ram_wr_d   = sel_we;
                    ram_dout_d = sel_wdata[7:0];
                end
            end
            XFER: begin
                // read data lags its address by one cycle
                if (!we_q && k_q != 2'd0) result_d[{cap_idx, 3'b000} +: 8] = ram_din_i;
                if (k_q != last_q) begin
                    k_d        = k_q + 2'd1;
                    ram_addr_d = base_q + ADDR_WIDTH'(k_d);
                    ram_wr_d   = we_q;
                    ram_dout_d = wdata_q[{k_d, 3'b000} +: 8];
                end else if (we_q) begin
                    mem_done_d = 1'b1;
                end
            end
            TAIL: begin
                result_d[{last_q, 3'b000} +: 8] = ram_din_i;
                if (own_mem_q) begin
                    mem_done_d  = 1'b1;
                    mem_rdata_d = result_d;
                end else begin
                    if_done_d = 1'b1;
                    if_data_d = result_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            k_q         <= 2'd0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            k_q         <= k_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // transaction context is only read after a fresh grant, so it needs no reset
    always_ff @(posedge clk) begin
        base_q    <= base_d;
        we_q      <= we_d;
        own_mem_q <= own_mem_d;
        last_q    <= last_d;
        wdata_q   <= wdata_d;
        result_q  <= result_d;
    end

    assign ram_addr_o  = ram_addr_q;
    assign ram_wr_o    = ram_wr_q;
    assign ram_dout_o  = ram_dout_q;
    assign if_done_o   = if_done_q;
    assign mem_done_o  = mem_done_q;
    assign if_data_o   = if_data_q;
    assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level timing model with per-cycle compare,
// plus directed scenarios pinned by hand-computed values.
module tb_mem_ctrl;

    localparam int DEPTH  = 1024;
    localparam bit PRIO_A = 1'b1;

    logic        clk;
    logic        rst;
    logic        if_req_i, mem_req_i, mem_we_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
    logic [1:0]  mem_size_i;
    logic [31:0] if_data_o, mem_rdata_o, ram_addr_o;
    logic        if_done_o, mem_done_o, ram_wr_o;
    logic [7:0]  ram_dout_o, ram_din_i;

    logic        b_if_req_i, b_mem_req_i, b_mem_we_i;
    logic [31:0] b_if_addr_i, b_mem_addr_i, b_mem_wdata_i;
    logic [1:0]  b_mem_size_i;
    logic [31:0] b_if_data_o, b_mem_rdata_o, b_ram_addr_o;
    logic        b_if_done_o, b_mem_done_o, b_ram_wr_o;
    logic [7:0]  b_ram_dout_o, b_ram_din_i;

    mem_ctrl #(.ADDR_WIDTH(32), .MEM_PRIO(PRIO_A)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
    );

    mem_ctrl #(.ADDR_WIDTH(32), .MEM_PRIO(1'b0)) u_dut_ifprio (
        .clk(clk), .rst(rst),
        .if_req_i(b_if_req_i), .if_addr_i(b_if_addr_i), .if_data_o(b_if_data_o), .if_done_o(b_if_done_o),
        .mem_req_i(b_mem_req_i), .mem_we_i(b_mem_we_i), .mem_size_i(b_mem_size_i), .mem_addr_i(b_mem_addr_i),
        .mem_wdata_i(b_mem_wdata_i), .mem_rdata_o(b_mem_rdata_o), .mem_done_o(b_mem_done_o),
        .ram_addr_o(b_ram_addr_o), .ram_wr_o(b_ram_wr_o), .ram_dout_o(b_ram_dout_o), .ram_din_i(b_ram_din_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] ram_a  [logic [31:0]];
    logic [7:0] ram_b  [logic [31:0]];
    logic [7:0] shadow [logic [31:0]];

    function automatic logic [7:0] rd_a(input logic [31:0] a);
        return ram_a.exists(a) ? ram_a[a] : 8'h00;
    endfunction
    function automatic logic [7:0] rd_b(input logic [31:0] a);
        return ram_b.exists(a) ? ram_b[a] : 8'h00;
    endfunction
    function automatic logic [7:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Byte RAMs: read data appears the cycle after its address
    initial begin : ram_env_a
        ram_din_i = 8'h00;
        forever begin
            @(posedge clk);
            if (!$isunknown(ram_addr_o)) begin
                ram_din_i <= rd_a(ram_addr_o);
                if (ram_wr_o === 1'b1) ram_a[ram_addr_o] = ram_dout_o;
            end
        end
    end
    initial begin : ram_env_b
        b_ram_din_i = 8'h00;
        forever begin
            @(posedge clk);
            if (!$isunknown(b_ram_addr_o)) begin
                b_ram_din_i <= rd_b(b_ram_addr_o);
                if (b_ram_wr_o === 1'b1) ram_b[b_ram_addr_o] = b_ram_dout_o;
            end
        end
    end

    // Expected outputs per absolute cycle number, filled by the model
    bit        exp_wr [DEPTH];
    bit        exp_ifd [DEPTH];
    bit        exp_memd [DEPTH];
    bit [31:0] exp_ifdata [DEPTH];
    bit [31:0] exp_memdata [DEPTH];
    bit        chk_addr [DEPTH];
    bit [31:0] exp_addr [DEPTH];
    bit        chk_dout [DEPTH];
    bit [7:0]  exp_dout [DEPTH];

    function automatic void clr(input int i);
        exp_wr[i] = 0; exp_ifd[i] = 0; exp_memd[i] = 0; exp_ifdata[i] = 0; exp_memdata[i] = 0;
        chk_addr[i] = 0; exp_addr[i] = 0; chk_dout[i] = 0; exp_dout[i] = 0;
    endfunction

    int          free_at = 0;
    int          m_c, m_n, m_done, pend_at, pend_n;
    bit          m_mem, m_we, pend_valid;
    logic [31:0] m_base, m_wd, m_data, pend_addr, pend_data;

    initial begin : model
        pend_valid = 0;
        forever begin
            @(posedge clk);
            m_c = cyc;
            if (pend_valid && m_c >= pend_at) begin
                for (int k = 0; k < pend_n; k++) shadow[pend_addr + 32'(k)] = pend_data[8*k +: 8];
                pend_valid = 0;
            end
            if (!rst) begin
                for (int i = m_c + 1; i < m_c + 16 && i < DEPTH; i++) clr(i);
                if (m_c + 1 < DEPTH) begin
                    chk_addr[m_c + 1] = 1;
                    chk_dout[m_c + 1] = 1;
                end
                pend_valid = 0;
                free_at = m_c + 1;
            end else if (m_c >= free_at && (if_req_i || mem_req_i) && m_c + 8 < DEPTH) begin
                m_mem  = mem_req_i && (!if_req_i || PRIO_A);
                m_base = m_mem ? mem_addr_i : if_addr_i;
                m_we   = m_mem && mem_we_i;
                m_wd   = mem_wdata_i;
                m_n    = !m_mem ? 4 : (mem_size_i == 2'b00) ? 1 : (mem_size_i == 2'b01) ? 2 : 4;
                m_data = 32'd0;
                for (int k = 0; k < m_n; k++) begin
                    exp_wr[m_c + 1 + k]   = m_we;
                    chk_addr[m_c + 1 + k] = 1;
                    exp_addr[m_c + 1 + k] = m_base + 32'(k);
                    if (m_we) begin
                        chk_dout[m_c + 1 + k] = 1;
                        exp_dout[m_c + 1 + k] = m_wd[8*k +: 8];
                    end else begin
                        m_data[8*k +: 8] = sh_rd(m_base + 32'(k));
                    end
                end
                m_done = m_c + m_n + (m_we ? 1 : 2);
                for (int t = m_c + m_n + 1; t <= m_done; t++) begin
                    chk_addr[t] = 1;
                    exp_addr[t] = m_base + 32'(m_n - 1);
                end
                if (m_mem) begin
                    exp_memd[m_done]    = 1;
                    exp_memdata[m_done] = m_we ? 32'd0 : m_data;
                end else begin
                    exp_ifd[m_done]    = 1;
                    exp_ifdata[m_done] = m_data;
                end
                if (m_we) begin
                    pend_valid = 1; pend_at = m_done; pend_addr = m_base; pend_n = m_n; pend_data = m_wd;
                end
                free_at = m_done + 1;
            end
            cyc = m_c + 1;
        end
    end

    bit cmp_ok;
    initial begin : compare
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < DEPTH) begin
                cmp_ok = (ram_wr_o === exp_wr[cyc]) && (if_done_o === exp_ifd[cyc]) &&
                         (mem_done_o === exp_memd[cyc]) && (if_data_o === exp_ifdata[cyc]) &&
                         (mem_rdata_o === exp_memdata[cyc]);
                if (chk_addr[cyc] && ram_addr_o !== exp_addr[cyc]) cmp_ok = 0;
                if (chk_dout[cyc] && ram_dout_o !== exp_dout[cyc]) cmp_ok = 0;
                checks++;
                if (!cmp_ok) begin
                    failures++;
                    $display("FAIL cycle%0d actual wr=%b ifd=%b memd=%b ifdata=%h memdata=%h addr=%h dout=%h required wr=%b ifd=%b memd=%b ifdata=%h memdata=%h addr=%h dout=%h",
                             cyc, ram_wr_o, if_done_o, mem_done_o, if_data_o, mem_rdata_o, ram_addr_o, ram_dout_o,
                             exp_wr[cyc], exp_ifd[cyc], exp_memd[cyc], exp_ifdata[cyc], exp_memdata[cyc],
                             exp_addr[cyc], exp_dout[cyc]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram_a[a]  = d;
        shadow[a] = d;
    endtask

    task automatic run_mem(input logic we, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd);
        int  t0;
        bit  seen;
        @(negedge clk);
        mem_we_i = we; mem_size_i = sz; mem_addr_i = a; mem_wdata_i = wd; mem_req_i = 1'b1;
        t0 = cyc; seen = 0; lat = -1; rd = 32'hFFFFFFFF;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (mem_done_o) begin
                seen = 1; lat = cyc - t0; rd = mem_rdata_o;
            end
        end
        mem_req_i = 1'b0;
    endtask

    task automatic run_if(input logic [31:0] a, output int lat, output logic [31:0] rd);
        int  t0;
        bit  seen;
        @(negedge clk);
        if_addr_i = a; if_req_i = 1'b1;
        t0 = cyc; seen = 0; lat = -1; rd = 32'hFFFFFFFF;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (if_done_o) begin
                seen = 1; lat = cyc - t0; rd = if_data_o;
            end
        end
        if_req_i = 1'b0;
    endtask

    int          lat, t0, cnt, d1, d2, a_if, a_mem, b_if, b_mem;
    logic [31:0] data, a_ifdata, b_ifdata, h1, h2;

    initial begin : main
        rst = 1'b0;
        if_req_i = 0; if_addr_i = 0; mem_req_i = 0; mem_we_i = 0; mem_size_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        b_if_req_i = 0; b_if_addr_i = 0; b_mem_req_i = 0; b_mem_we_i = 0; b_mem_size_i = 0;
        b_mem_addr_i = 0; b_mem_wdata_i = 0;
        preload(32'h100, 8'h13); preload(32'h101, 8'h00); preload(32'h102, 8'h00); preload(32'h103, 8'h93);
        preload(32'hFFFFFFFF, 8'h80); preload(32'h0, 8'hFF);
        ram_b[32'h0] = 8'h11; ram_b[32'h1] = 8'h22; ram_b[32'h2] = 8'h33; ram_b[32'h3] = 8'h44;

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {29'd0, if_done_o, mem_done_o, ram_wr_o}, 32'd0);
        chk("reset_addr", ram_addr_o, 32'd0);
        chk("reset_data", if_data_o | mem_rdata_o | {24'd0, ram_dout_o}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_if(32'h100, lat, data);
        chk("if_fetch_latency", lat, 6);
        chk("if_fetch_data", data, 32'h93000013);

        run_mem(1'b1, 2'b00, 32'h1000, 32'h123456AB, lat, data);
        chk("sb_latency", lat, 2);
        chk("sb_rdata", data, 32'd0);
        chk("sb_byte", {24'd0, rd_a(32'h1000)}, 32'hAB);
        chk("sb_next_untouched", {24'd0, rd_a(32'h1001)}, 32'h00);

        run_mem(1'b0, 2'b01, 32'hFFFFFFFF, 32'd0, lat, data);
        chk("lh_wrap_latency", lat, 4);
        chk("lh_wrap_data", data, 32'h0000FF80);

        // Simultaneous IF fetch and MEM word store on both priority settings
        @(negedge clk);
        if_addr_i = 0; if_req_i = 1;
        mem_we_i = 1; mem_size_i = 2'b10; mem_addr_i = 32'h2000; mem_wdata_i = 32'hDEADBEEF; mem_req_i = 1;
        b_if_addr_i = 0; b_if_req_i = 1;
        b_mem_we_i = 1; b_mem_size_i = 2'b10; b_mem_addr_i = 32'h2000; b_mem_wdata_i = 32'hDEADBEEF; b_mem_req_i = 1;
        t0 = cyc; a_if = -1; a_mem = -1; b_if = -1; b_mem = -1; a_ifdata = 0; b_ifdata = 0;
        for (int i = 0; i < 40 && (a_if < 0 || a_mem < 0 || b_if < 0 || b_mem < 0); i++) begin
            @(negedge clk);
            if (mem_done_o)   begin a_mem = cyc - t0; mem_req_i = 0; end
            if (if_done_o)    begin a_if = cyc - t0; a_ifdata = if_data_o; if_req_i = 0; end
            if (b_mem_done_o) begin b_mem = cyc - t0; b_mem_req_i = 0; end
            if (b_if_done_o)  begin b_if = cyc - t0; b_ifdata = b_if_data_o; b_if_req_i = 0; end
        end
        chk("memprio1_mem_done", a_mem, 5);
        chk("memprio1_if_done", a_if, 12);
        chk("memprio1_if_data", a_ifdata, 32'h000000FF);
        chk("memprio1_sw_bytes", {rd_a(32'h2003), rd_a(32'h2002), rd_a(32'h2001), rd_a(32'h2000)}, 32'hDEADBEEF);
        chk("memprio0_if_done", b_if, 6);
        chk("memprio0_mem_done", b_mem, 12);
        chk("memprio0_if_data", b_ifdata, 32'h44332211);
        chk("memprio0_sw_bytes", {rd_b(32'h2003), rd_b(32'h2002), rd_b(32'h2001), rd_b(32'h2000)}, 32'hDEADBEEF);

        // Reset at the edge ending the k=1 cycle of a word store
        @(negedge clk);
        mem_we_i = 1; mem_size_i = 2'b10; mem_addr_i = 32'h3000; mem_wdata_i = 32'h11223344; mem_req_i = 1;
        @(negedge clk);
        chk("sw_k0_addr", ram_addr_o, 32'h3000);
        @(negedge clk);
        rst = 1'b0; mem_req_i = 0;
        @(negedge clk);
        chk("rst_mid_wr", {31'd0, ram_wr_o}, 32'd0);
        chk("rst_mid_addr", ram_addr_o, 32'd0);
        rst = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_done_o) cnt++;
        end
        chk("rst_mid_no_done", cnt, 0);
        chk("rst_mid_bytes", {rd_a(32'h3002), rd_a(32'h3001), rd_a(32'h3000)}, 32'h00003344);

        run_mem(1'b0, 2'b00, 32'h1000, 32'd0, lat, data);
        chk("lb_after_rst_latency", lat, 3);
        chk("lb_after_rst_data", data, 32'h000000AB);

        // Request held through DONE is re-served from the following IDLE
        @(negedge clk);
        mem_we_i = 0; mem_size_i = 2'b00; mem_addr_i = 32'h100; mem_req_i = 1;
        t0 = cyc; cnt = 0; d1 = -1; d2 = -1; h1 = 0; h2 = 0;
        for (int i = 0; i < 20 && cnt < 2; i++) begin
            @(negedge clk);
            if (mem_done_o) begin
                if (cnt == 0) begin d1 = cyc - t0; h1 = mem_rdata_o; end
                else          begin d2 = cyc - t0; h2 = mem_rdata_o; mem_req_i = 0; end
                cnt++;
            end
        end
        chk("held_done_count", cnt, 2);
        chk("held_first_done", d1, 3);
        chk("held_second_done", d2, 7);
        chk("held_data", h1 | (h2 << 8), 32'h00001313);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates and sequences the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Splits each word, halfword or byte access into consecutive byte transfers and assembles read bytes little-endian.
- Returns a one-cycle done pulse with data to the requester that owns the transaction.
- Sits between the pipeline and the external RAM; sign extension is not done here (the MEM stage does it).

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- MEM_PRIO, 1, tie-break when IF and MEM request in the same IDLE cycle: 1 = MEM wins, 0 = IF wins.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-low: rst==0 at a rising edge resets the block.
- if_req_i  in  1  IF read request; held high until if_done_o.
- if_addr_i  in  ADDR_WIDTH  IF fetch address; always a 4-byte read.
- if_data_o  out  32  fetched word; valid only while if_done_o==1.
- if_done_o  out  1  one-cycle completion pulse to IF.
- mem_req_i  in  1  MEM request; held high until mem_done_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  00 = byte, 01 = half, 10 or 11 = word.
- mem_addr_i  in  ADDR_WIDTH  MEM base address.
- mem_wdata_i  in  32  store data; the low N bytes are used.
- mem_rdata_o  out  32  load data, zero-extended; valid only while mem_done_o==1.
- mem_done_o  out  1  one-cycle completion pulse to MEM.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address.
- ram_wr_o  out  1  RAM write enable.
- ram_dout_o  out  8  RAM write byte.
- ram_din_i  in  8  RAM read byte; presents data for the address driven in the previous cycle.

Behaviour:
- **Registered outputs.** All outputs are registered. On reset every output is 0 and the state is IDLE.
- **States:**
  - IDLE: arbitrate.
  - XFER: drive byte addresses and data.
  - TAIL: capture the last read byte.
  - DONE: assert done for one cycle.
- **IDLE arbitration.** Requests are sampled at the edge ending the IDLE cycle T.
  - If both requests are high, MEM_PRIO decides the winner.
  - If one request is high, that requester wins.
  - The winner's address, size, we and wdata are latched; N = 1, 2 or 4 bytes; byte counter k = 0.
  - Inputs are ignored until DONE.
- **Byte addressing.** In XFER cycles T+1..T+N: ram_addr_o = base + k, computed modulo 2^ADDR_WIDTH (wraps 0xFFFFFFFF -> 0x00000000). Misaligned bases are legal.
- **Store.**
  - In XFER: ram_wr_o = 1, ram_dout_o = wdata[8k+7:8k].
  - After k = N-1, go to DONE. mem_done_o = 1 at T+N+1.
- **Load / fetch.**
  - In XFER: ram_wr_o = 0.
  - The byte for address base+k arrives on ram_din_i one cycle later and is stored to result bits [8k+7:8k]. Bytes arrive in T+2..T+N+1.
  - After the last address cycle, go to TAIL (capture byte N-1), then DONE.
  - Done = 1 at T+N+2; unused upper bytes are 0.
- **DONE cycle.**
  - Exactly one of if_done_o / mem_done_o is 1, together with the data output.
  - ram_wr_o = 0 and ram_addr_o holds.
  - Requests are ignored in DONE (the requester's req may still be high); the next arbitration is in the following IDLE cycle.
  - The requester drops req by the edge ending DONE or issues its next request.
- **Outside XFER.** ram_wr_o = 0 in IDLE, TAIL and DONE. ram_addr_o and ram_dout_o hold their last value.
- **Data outputs outside DONE.** if_data_o and mem_rdata_o are 0 outside DONE. Stores return mem_rdata_o = 0.
- **Reset mid-transaction.** Abort: at the next edge ram_wr_o = 0, no done pulse, state IDLE, latched request discarded.
- **Request dropped mid-transaction.** This is a protocol error; the transaction still completes and done is still pulsed.
- **Throughput.** A word fetch costs 7 cycles IDLE-to-IDLE. Back-to-back requests have a minimum of one IDLE cycle between DONE and the next XFER.

Test Plan:
- **IF fetch.** RAM[0x100..0x103] = 13,00,00,93; if_req at 0x100 in IDLE cycle T -> ram_addr 0x100..0x103 in T+1..T+4, ram_wr 0; if_done=1 with if_data=0x93000013 at T+6 only.
- **SB.** mem_req, we=1, size=00, addr 0x1000, wdata 0x123456AB -> one write cycle: ram_wr=1, addr 0x1000, dout 0xAB; mem_done at T+2; RAM[0x1001] untouched.
- **Simultaneous requests, MEM_PRIO=1.**
  - Stimulus: IF at 0x0 and MEM SW 0xDEADBEEF at 0x2000.
  - Required bytes: EF,BE,AD,DE written to 0x2000..0x2003.
  - Pulse order: mem_done first, then one IDLE cycle, then the IF fetch, then if_done.
  - Repeat with MEM_PRIO=0 -> IF is served first.
- **LH wrap-around.** RAM[0xFFFFFFFF]=0x80, RAM[0x0]=0xFF -> addresses 0xFFFFFFFF then 0x00000000; mem_rdata=0x0000FF80 (zero-extended).
- **Reset mid-transaction.** rst=0 at the edge ending the k=1 cycle of an SW -> next cycle ram_wr=0, all outputs 0, no mem_done. After rst=1, a new LB serves normally with done at T+3.
- **Request held through DONE.** Keep mem_req high through DONE -> no re-issue in the DONE cycle; a new transaction starts from the following IDLE, and exactly one done pulse occurs per transaction.
